// File: rtl/ttl_bcd_display_scanner.sv
// Multiplexed 7-segment scanner for a cascaded BCD counter chain.
// Frame snapshot, leading-zero blanking, lamp test, dead time.
module ttl_bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  MR,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DP_in,
  input  logic                  LT_n,
  input  logic                  BL_n,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     DIG_n,
  output logic                  FRAME
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   fr_bcd;
  logic [DIGITS-1:0]     fr_dp;
  logic                  load_pending;

  logic                  slot_end;
  logic                  frame_end;
  logic                  capture;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic [DIGITS-1:0]     lz;
  logic                  blank;

  assign slot_end  = (pcnt == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);
  assign capture   = load_pending || frame_end;

  assign cur_bcd = fr_bcd[{idx, 2'b00} +: 4];
  assign cur_dp  = fr_dp[idx];
  assign blank   = lz[idx];

  // Active-low g..a pattern; error codes show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Leading-zero mask: walk down from the top digit while
  // every digit so far is zero with no decimal point requested.
  always_comb begin
    logic run;
    lz  = '0;
    run = (BLANK_LZ != 0);
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run   = run && (fr_bcd[4*i +: 4] == 4'd0) && !fr_dp[i];
      lz[i] = run;
    end
  end

  // Prescaler and digit index; idx steps on the last slot clock.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      if (slot_end) begin
        pcnt <= '0;
        idx  <= (idx == I_LAST) ? '0 : idx + IW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Frame snapshot on the first edge after reset and at each idx wrap.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      fr_bcd       <= '0;
      fr_dp        <= '0;
      load_pending <= 1'b1;
    end else if (capture) begin
      fr_bcd       <= BCD;
      fr_dp        <= DP_in;
      load_pending <= 1'b0;
    end
  end

  // Registered digit enables: blanking, then dead cycle, then select.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      DIG_n <= '1;
    end else if (!BL_n || (pcnt == '0)) begin
      DIG_n <= '1;
    end else begin
      DIG_n <= ~(DIGITS'(1) << idx);
    end
  end

  // Registered segments: lamp test, then blanking, then decode.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
    end else if (!LT_n) begin
      SEG <= 7'h00;
      DP  <= 1'b0;
    end else if (blank) begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      SEG <= seg7(cur_bcd);
      DP  <= ~cur_dp;
    end
  end

  // One-clock pulse following every snapshot.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      FRAME <= 1'b0;
    end else begin
      FRAME <= capture;
    end
  end

endmodule

// File: tb/tb_ttl_bcd_display_scanner.sv
// Randomized bench for ttl_bcd_display_scanner with a
// cycle-count based reference model.
module tb_ttl_bcd_display_scanner;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int P  = D * SD;

  logic        clk = 1'b0;
  logic        MR;
  logic [15:0] BCD;
  logic [3:0]  DP_in;
  logic        LT_n;
  logic        BL_n;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  DIG_n;
  logic        FRAME;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ttl_bcd_display_scanner #(
    .DIGITS(D),
    .SCAN_DIV(SD),
    .BLANK_LZ(1)
  ) dut (
    .clk(clk),
    .MR(MR),
    .BCD(BCD),
    .DP_in(DP_in),
    .LT_n(LT_n),
    .BL_n(BL_n),
    .SEG(SEG),
    .DP(DP),
    .DIG_n(DIG_n),
    .FRAME(FRAME)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0111111;
    return tab[v];
  endfunction

  // Reference: k = clock edges since reset release.
  int         k;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_dig;
  logic        exp_frame;

  always @(posedge clk or posedge MR) begin : model
    int  pos;
    int  slot;
    bit  blank;
    if (MR) begin
      k         = 0;
      m_bcd     = '0;
      m_dp      = '0;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
      exp_dig   = 4'hF;
      exp_frame = 1'b0;
    end else begin
      pos  = k % SD;
      slot = (k / SD) % D;
      exp_dig = (!BL_n || pos == 0) ? 4'hF : ~(4'b0001 << slot);
      blank = 1'b0;
      if (slot > 0) begin
        blank = 1'b1;
        for (int j = slot; j < D; j++)
          if (m_bcd[4*j +: 4] != 4'd0 || m_dp[j]) blank = 1'b0;
      end
      if (!LT_n) begin
        exp_seg = 7'h00;
        exp_dp  = 1'b0;
      end else if (blank) begin
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_seg = ref_seg(m_bcd[4*slot +: 4]);
        exp_dp  = ~m_dp[slot];
      end
      exp_frame = (k == 0) || ((k + 1) % P == 0);
      if (exp_frame) begin
        m_bcd = BCD;
        m_dp  = DP_in;
      end
      k++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("dig_n", 32'(DIG_n), 32'(exp_dig));
    check("frame", 32'(FRAME), 32'(exp_frame));
    if (exp_dig != 4'hF) begin
      check("seg", 32'(SEG), 32'(exp_seg));
      check("dp", 32'(DP), 32'(exp_dp));
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_seg"}, 32'(SEG), 32'h7F);
    check({tag, "_dp"}, 32'(DP), 32'h1);
    check({tag, "_dig"}, 32'(DIG_n), 32'hF);
    check({tag, "_frame"}, 32'(FRAME), 32'h0);
  endtask

  task automatic mr_pulse();
    #2 MR = 1'b1;
    #1 check_reset_outs("mr_async");
    tick();
    MR = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          nz;
    bit          found;
    MR    = 1'b1;
    BCD   = 16'h1234;
    DP_in = 4'b0000;
    LT_n  = 1'b1;
    BL_n  = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    MR = 1'b0;
    run(40);

    BCD = 16'h0007;
    run(32);
    DP_in = 4'b0100;
    run(32);

    BCD   = 16'h0009;
    DP_in = 4'b0000;
    run(20);
    BCD = 16'h0010;
    run(40);

    BCD = 16'h000B;
    run(20);
    LT_n = 1'b0;
    run(20);
    LT_n = 1'b1;

    run(3);
    BL_n = 1'b0;
    run(10);
    BL_n = 1'b1;
    run(20);

    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      tick();
      if (((k / SD) % D) == 2 && (k % SD) == 2) found = 1'b1;
    end
    check("slot2_reached", 32'(found), 32'h1);
    mr_pulse();
    run(40);

    for (int r = 0; r < 40; r++) begin
      v  = '0;
      nz = $urandom_range(0, 4);
      for (int i = 0; i < nz; i++)
        v[4*i +: 4] = ($urandom_range(0, 5) == 0) ?
                      4'($urandom_range(10, 15)) :
                      4'($urandom_range(0, 9));
      BCD   = v;
      DP_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      LT_n  = ($urandom_range(0, 7) != 0);
      BL_n  = ($urandom_range(0, 5) != 0);
      run($urandom_range(3, 40));
      if ($urandom_range(0, 9) == 0) mr_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
